mem_port_arbiter: RTL

//  Shares one single-port memory between two requesters of the CPU datapath:

---
 rtl/mem_port_arbiter_if.sv | 49 ++++
 rtl/mem_port_arbiter.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the shared memory.
// The slave modport is the arbiter's view; master is the surrounding system
// (CPU ports plus memory model).
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    // Port 0: data load/store
    logic          m0_req;
    logic          m0_we;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m0_ack;
    logic [DW-1:0] m0_rdata;
    logic          m0_err;
    // Port 1: instruction fetch / loader
    logic          m1_req;
    logic          m1_we;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_ack;
    logic [DW-1:0] m1_rdata;
    logic          m1_err;
    // Memory side
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ready;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_ack, m0_rdata, m0_err,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m1_ack, m1_rdata, m1_err,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_ack, m0_rdata, m0_err,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m1_ack, m1_rdata, m1_err,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of a single-port memory. One transaction at a
// time walks IDLE -> BUSY -> RESP; the winner is picked round-robin or with
// fixed port-0 priority, and a stuck memory is cut off after TIMEOUT cycles
// with an error completion. Every output comes straight from a flop.
module mem_port_arbiter #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int ROUND_ROBIN = 1,
    parameter int TIMEOUT     = 16
) (
    input  logic             clk,
    input  logic             rst,
    mem_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_RESP
    } state_e;

    // Wide enough to hold TIMEOUT-1; unused width is harmless when TIMEOUT=0.
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    state_e                state_q,      state_d;
    logic                  last_grant_q, last_grant_d;
    logic                  winner_q,     winner_d;
    logic [CW-1:0]         cnt_q,        cnt_d;
    logic                  mem_req_q,    mem_req_d;
    logic                  mem_we_q,     mem_we_d;
    logic [AW-1:0]         mem_addr_q,   mem_addr_d;
    logic [DW-1:0]         mem_wdata_q,  mem_wdata_d;
    logic [1:0]            ack_q,        ack_d;
    logic [1:0]            err_q,        err_d;
    logic [1:0][DW-1:0]    rdata_q,      rdata_d;

    logic grant;
    logic timeout_hit;

    // Winner of a new transaction: a lone requester wins; on contention either
    // alternate away from the last grant or let port 0 win outright.
    always_comb begin
        if (bus.m0_req && bus.m1_req) begin
            grant = (ROUND_ROBIN != 0) ? ~last_grant_q : 1'b0;
        end else begin
            grant = bus.m1_req;
        end
    end

    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

    // Next-state and output-register logic for the transaction FSM.
    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the case leaves one unassigned (no latches).
        state_d      = state_q;
        last_grant_d = last_grant_q;
        winner_d     = winner_q;
        cnt_d        = cnt_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        ack_d        = '0;
        err_d        = err_q;
        rdata_d      = rdata_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.m0_req || bus.m1_req) begin
                    state_d      = S_BUSY;
                    winner_d     = grant;
                    last_grant_d = grant;
                    cnt_d        = '0;
                    mem_req_d    = 1'b1;
                    mem_we_d     = grant ? bus.m1_we    : bus.m0_we;
                    mem_addr_d   = grant ? bus.m1_addr  : bus.m0_addr;
                    mem_wdata_d  = grant ? bus.m1_wdata : bus.m0_wdata;
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q + CW'(1);
                // A ready memory beats a simultaneous timeout.
                if (bus.mem_ready || timeout_hit) begin
                    state_d           = S_RESP;
                    mem_req_d         = 1'b0;
                    ack_d[winner_q]   = 1'b1;
                    rdata_d[winner_q] = bus.mem_ready ? bus.mem_rdata : '0;
                    err_d[winner_q]   = ~bus.mem_ready;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: all state is cleared on reset -- there is no storage array here that could be left unreset.
        if (!rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            winner_q     <= 1'b0;
            cnt_q        <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            ack_q        <= '0;
            err_q        <= '0;
            rdata_q      <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            winner_q     <= winner_d;
            cnt_q        <= cnt_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
            rdata_q      <= rdata_d;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.m0_ack    = ack_q[0];
    assign bus.m1_ack    = ack_q[1];
    assign bus.m0_err    = err_q[0];
    assign bus.m1_err    = err_q[1];
    assign bus.m0_rdata  = rdata_q[0];
    assign bus.m1_rdata  = rdata_q[1];

endmodule
